// File: rtl/pipeline_stall_controller_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipeline_stall_controller_pkg: state encoding and shared constants     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package pipeline_stall_controller_pkg;

  localparam logic [1:0] INIT      = 2'd0;
  localparam logic [1:0] RUN       = 2'd1;
  localparam logic [1:0] DMEM_WAIT = 2'd2;
  localparam logic [1:0] HALT      = 2'd3;

  typedef enum logic [1:0] {
    ST_INIT      = INIT,
    ST_RUN       = RUN,
    ST_DMEM_WAIT = DMEM_WAIT,
    ST_HALT      = HALT
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_stall_controller_sat_counter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | sat_counter: up-counter that sticks at all-ones instead of wrapping    |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pipeline_stall_controller: stall/flush/bubble sequencer for the 5-stage|
// | RV32I pipeline, with reset purge and data-memory timeout halt.         |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int INIT_CYCLES  = 4,
  parameter int DMEM_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             ifid_uses_rs1,
  input  logic             ifid_uses_rs2,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             halted,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // One counter serves both the reset purge and the memory-wait timeout.
  localparam int WAIT_W = $clog2(max_int(INIT_CYCLES, DMEM_TIMEOUT) + 1);
  localparam logic [WAIT_W-1:0] C_INIT_LAST = WAIT_W'(INIT_CYCLES - 1);
  localparam logic [WAIT_W-1:0] C_TIMEOUT   = WAIT_W'(DMEM_TIMEOUT);

  state_t              r_state;
  state_t              w_next_state;
  logic [WAIT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]   w_next_cnt;
  logic                w_advance;
  logic                w_load_use;
  logic                w_inc_flush;
  logic                w_inc_stall;

  assign w_load_use = idex_memread && (idex_rd != REG_X0) &&
                      ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                       (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    halted       = 1'b0;
    mem_fault    = 1'b0;
    w_advance    = 1'b0;
    w_inc_flush  = 1'b0;
    w_next_state = r_state;
    w_next_cnt   = r_cnt;

    case (r_state)
      ST_INIT: begin
        pc_write     = 1'b0;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        memwb_bubble = 1'b1;
        if (r_cnt == C_INIT_LAST) begin
          w_next_state = ST_RUN;
          w_next_cnt   = '0;
        end else begin
          w_next_cnt = r_cnt + WAIT_W'(1);
        end
      end
      ST_RUN: begin
        if (dmem_req && !dmem_ready) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          w_next_state = ST_DMEM_WAIT;
          w_next_cnt   = WAIT_W'(1);
        end else begin
          w_advance = 1'b1;
        end
      end
      ST_DMEM_WAIT: begin
        if (dmem_ready) begin
          w_advance    = 1'b1;
          w_next_state = ST_RUN;
          w_next_cnt   = '0;
        end else begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          if (r_cnt == C_TIMEOUT) begin
            mem_fault    = 1'b1;
            w_next_state = ST_HALT;
          end else begin
            w_next_cnt = r_cnt + WAIT_W'(1);
          end
        end
      end
      default: begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b1;
        halted       = 1'b1;
      end
    endcase

    // Lower-priority sources, applied whenever the memory stage is not holding.
    if (w_advance) begin
      if (ex_branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        w_inc_flush = 1'b1;
      end else if (w_load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end else if (!imem_ready) begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  assign w_inc_stall = ((r_state == ST_RUN) || (r_state == ST_DMEM_WAIT)) && !pc_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc_stall),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_inc_flush),
    .count (flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pipeline_stall_controller: scenario bench with a per-cycle scoreboard|
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pipeline_stall_controller;

  localparam int INIT_CYCLES  = 4;
  localparam int DMEM_TIMEOUT = 16;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
  //  exmem_write, exmem_bubble, memwb_bubble, halted, mem_fault}
  localparam logic [9:0] C_INIT  = 10'b0111111100;
  localparam logic [9:0] C_DEF   = 10'b1101010000;
  localparam logic [9:0] C_DSTL  = 10'b0000000100;
  localparam logic [9:0] C_FAULT = 10'b0000000101;
  localparam logic [9:0] C_HALT  = 10'b0000000110;
  localparam logic [9:0] C_BR    = 10'b1111110000;
  localparam logic [9:0] C_LU    = 10'b0001110000;
  localparam logic [9:0] C_IMW   = 10'b0111010000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       ifid_rs1, ifid_rs2, idex_rd;
  logic             ifid_uses_rs1, ifid_uses_rs2, idex_memread;
  logic             ex_branch_taken, imem_ready, dmem_req, dmem_ready;
  logic             pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic             exmem_write, exmem_bubble, memwb_bubble, halted, mem_fault;
  logic [CNT_W-1:0] stall_cycles, flush_count;
  logic [9:0]       obs;

  typedef struct {
    logic [9:0]       ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_stall = 0;
  int   exp_flush = 0;

  always #5 clk = ~clk;

  assign obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
                exmem_write, exmem_bubble, memwb_bubble, halted, mem_fault};

  pipeline_stall_controller #(
    .INIT_CYCLES  (INIT_CYCLES),
    .DMEM_TIMEOUT (DMEM_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ifid_rs1        (ifid_rs1),
    .ifid_rs2        (ifid_rs2),
    .ifid_uses_rs1   (ifid_uses_rs1),
    .ifid_uses_rs2   (ifid_uses_rs2),
    .idex_memread    (idex_memread),
    .idex_rd         (idex_rd),
    .ex_branch_taken (ex_branch_taken),
    .imem_ready      (imem_ready),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_bubble     (idex_bubble),
    .exmem_write     (exmem_write),
    .exmem_bubble    (exmem_bubble),
    .memwb_bubble    (memwb_bubble),
    .halted          (halted),
    .mem_fault       (mem_fault),
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
  );

  task automatic idle_inputs();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; ifid_uses_rs1 = 1'b0; ifid_uses_rs2 = 1'b0;
    idex_memread = 1'b0; idex_rd = 5'd0; ex_branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic lu_inputs(input logic [4:0] rd);
    idex_memread = 1'b1; idex_rd = rd;
    ifid_rs1 = 5'd3; ifid_uses_rs1 = 1'b1;
    ifid_rs2 = rd;   ifid_uses_rs2 = 1'b1;
  endtask

  // Called at posedge+1; inputs are already applied. Samples mid-cycle.
  task automatic step(input logic [9:0] ctl, input bit counted, input string name);
    exp_t e;
    e.ctl   = ctl;
    e.stall = CNT_W'(exp_stall);
    e.flush = CNT_W'(exp_flush);
    sb.push_back(e);
    #3;
    e = sb.pop_front();
    total++;
    if (obs !== e.ctl) begin
      bad++;
      $display("FAIL %s ctl: got %b want %b", name, obs, e.ctl);
    end
    total++;
    if (stall_cycles !== e.stall) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles, e.stall);
    end
    total++;
    if (flush_count !== e.flush) begin
      bad++;
      $display("FAIL %s flush_count: got %0d want %0d", name, flush_count, e.flush);
    end
    if (counted) begin
      if (!ctl[9] && exp_stall < CNT_MAX) exp_stall++;
      if (ctl[9] && ctl[7] && ctl[5] && exp_flush < CNT_MAX) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks the asynchronous response, releases at posedge+1.
  task automatic do_reset(input string name);
    rst = 1'b1;
    idle_inputs();
    exp_stall = 0;
    exp_flush = 0;
    #2;
    total++;
    if (obs !== C_INIT) begin
      bad++;
      $display("FAIL %s async reset ctl: got %b want %b", name, obs, C_INIT);
    end
    total++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      bad++;
      $display("FAIL %s reset counters: got %0d/%0d want 0/0", name, stall_cycles, flush_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_init(input string name);
    for (int i = 0; i < INIT_CYCLES; i++) step(C_INIT, 1'b0, name);
  endtask

  task automatic test_reset();
    do_reset("reset");
    run_init("reset_init");
    step(C_DEF, 1'b1, "reset_run");
    step(C_DEF, 1'b1, "reset_run2");
  endtask

  task automatic test_load_use();
    do_reset("lu");
    run_init("lu_init");
    lu_inputs(5'd5);
    step(C_LU, 1'b1, "lu_rs2");
    idle_inputs();
    step(C_DEF, 1'b1, "lu_after");
    lu_inputs(5'd0);
    step(C_DEF, 1'b1, "lu_x0");
    idle_inputs();
    idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_uses_rs1 = 1'b1;
    step(C_LU, 1'b1, "lu_rs1");
    ifid_uses_rs1 = 1'b0;
    step(C_DEF, 1'b1, "lu_rs1_unused");
    idex_memread = 1'b0; ifid_uses_rs1 = 1'b1;
    step(C_DEF, 1'b1, "lu_not_load");
  endtask

  task automatic test_branch_lu();
    do_reset("brlu");
    run_init("brlu_init");
    lu_inputs(5'd5);
    ex_branch_taken = 1'b1;
    step(C_BR, 1'b1, "brlu_both");
    idle_inputs();
    step(C_DEF, 1'b1, "brlu_after");
  endtask

  task automatic test_imem();
    do_reset("imem");
    run_init("imem_init");
    imem_ready = 1'b0;
    step(C_IMW, 1'b1, "imem_wait");
    lu_inputs(5'd9);
    step(C_LU, 1'b1, "imem_lu");
    idle_inputs();
    imem_ready = 1'b0; ex_branch_taken = 1'b1;
    step(C_BR, 1'b1, "imem_br");
    idle_inputs();
    step(C_DEF, 1'b1, "imem_after");
  endtask

  task automatic test_dmem();
    do_reset("dmem");
    run_init("dmem_init");
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step(C_DSTL, 1'b1, "dmem_wait");
    dmem_ready = 1'b1;
    step(C_DEF, 1'b1, "dmem_ready");
    idle_inputs();
    step(C_DEF, 1'b1, "dmem_after");
  endtask

  task automatic test_timeout();
    do_reset("tmo");
    run_init("tmo_init");
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < DMEM_TIMEOUT; i++) step(C_DSTL, 1'b1, "tmo_wait");
    step(C_FAULT, 1'b1, "tmo_fault");
    step(C_HALT, 1'b0, "tmo_halt");
    ex_branch_taken = 1'b1; dmem_ready = 1'b1;
    step(C_HALT, 1'b0, "tmo_halt_ign");
    idle_inputs();
    step(C_HALT, 1'b0, "tmo_halt_idle");
    do_reset("tmo_rst_halt");
    run_init("tmo_reinit");
    step(C_DEF, 1'b1, "tmo_rerun");
  endtask

  task automatic test_late_ready();
    do_reset("late");
    run_init("late_init");
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < DMEM_TIMEOUT; i++) step(C_DSTL, 1'b1, "late_wait");
    dmem_ready = 1'b1;
    step(C_DEF, 1'b1, "late_ready");
    idle_inputs();
    step(C_DEF, 1'b1, "late_run");
    step(C_DEF, 1'b1, "late_run2");
  endtask

  task automatic test_saturation();
    do_reset("sat");
    run_init("sat_init");
    lu_inputs(5'd12);
    for (int i = 0; i < 20; i++) step(C_LU, 1'b1, "sat_stall");
    idle_inputs();
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 18; i++) step(C_BR, 1'b1, "sat_flush");
    idle_inputs();
    step(C_DEF, 1'b1, "sat_hold");
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_use();
    test_branch_lu();
    test_imem();
    test_dmem();
    test_timeout();
    test_late_ready();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage RV32I pipeline registers (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Arbitrates four stall/flush sources: data-memory wait, taken branch/jump, load-use hazard and instruction-memory wait.
- Emits per-stage write-enable, flush and bubble controls, and runs a post-reset pipeline purge.
- Enforces a data-memory timeout that halts the core, and keeps saturating stall and flush performance counters.

Parameters:
- INIT_CYCLES, 4, cycles of forced bubbles after reset release before fetch starts (≥1).
- DMEM_TIMEOUT, 16, max consecutive DMEM_WAIT cycles before fault (≥2).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- ifid_rs1  in  5  rs1 field of the instruction in ID.
- ifid_rs2  in  5  rs2 field of the instruction in ID.
- ifid_uses_rs1  in  1  ID instruction reads rs1.
- ifid_uses_rs2  in  1  ID instruction reads rs2.
- idex_memread  in  1  instruction in EX is a load.
- idex_rd  in  5  rd of the instruction in EX.
- ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle.
- imem_ready  in  1  fetch data valid this cycle.
- dmem_req  in  1  MEM stage holds a load or store.
- dmem_ready  in  1  data memory completes access this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_write  out  1  ID/EX load enable.
- idex_bubble  out  1  control mux selects zeros into ID/EX.
- exmem_write  out  1  EX/MEM load enable.
- exmem_bubble  out  1  EX/MEM loads a NOP.
- memwb_bubble  out  1  MEM/WB loads a NOP.
- halted  out  1  core halted after memory fault.
- mem_fault  out  1  one-cycle pulse on timeout.
- stall_cycles  out  CNT_W  count of cycles with pc_write=0 in RUN or DMEM_WAIT.
- flush_count  out  CNT_W  count of taken-branch flushes.

Behaviour:
- States: INIT, RUN, DMEM_WAIT, HALT. Registered state and a wait/init counter. Outputs are combinational (Mealy) from state and inputs.
- Reset (asynchronous, any time, including mid-wait):
  - state=INIT, counter=0, both perf counters=0, mem_fault=0, halted=0.
  - Outputs take INIT values immediately.
- Default outputs: all writes=1, all flush/bubble=0, pc_write=1.
- INIT:
  - pc_write=0, ifid_flush=1, idex_bubble=1, exmem_bubble=1, memwb_bubble=1; other writes=1.
  - Counter increments each cycle; after INIT_CYCLES cycles go to RUN. Inputs are ignored.
- RUN, evaluated in strict priority order (highest first):
  1. dmem_req & !dmem_ready:
     - pc_write=0, ifid_write=0, idex_write=0, exmem_write=0, memwb_bubble=1.
     - Next state DMEM_WAIT, counter=1.
  2. ex_branch_taken: pc_write=1, ifid_flush=1, idex_bubble=1; flush_count+1.
  3. load_use: pc_write=0, ifid_write=0, idex_bubble=1.
     - load_use = idex_memread & idex_rd≠0 & ((ifid_uses_rs1 & ifid_rs1==idex_rd) | (ifid_uses_rs2 & ifid_rs2==idex_rd)).
     - x0 never stalls.
  4. !imem_ready: pc_write=0, ifid_flush=1; downstream stages advance.
  5. Otherwise defaults.
- Load-use plus imem wait in the same cycle: load_use wins, and IF/ID is held, not flushed.
- Branch plus imem wait: branch wins; the PC loads the target.
- DMEM_WAIT:
  - Freeze outputs as RUN case 1 while dmem_ready=0; counter increments.
  - dmem_ready=1: outputs per RUN priority 2–5 (the pipeline advances this cycle); next state RUN.
  - counter==DMEM_TIMEOUT with dmem_ready=0: mem_fault=1 for that cycle; next state HALT.
  - A late ready in the timeout cycle still wins: no fault, return to RUN.
- HALT:
  - pc_write=0, all writes=0, memwb_bubble=1, halted=1.
  - Held until reset; all inputs ignored.
- Counters:
  - stall_cycles increments on each RUN/DMEM_WAIT cycle with pc_write=0. INIT and HALT are not counted.
  - Both counters saturate at all-ones and never wrap.

Decomposition:
- Shared package holds:
  - state encoding localparams (INIT=0, RUN=1, DMEM_WAIT=2, HALT=3);
  - the REG_X0 constant (5'd0).
- One sub-module, sat_counter (parameter W; ports clk, rst, inc, count), instantiated twice for the perf counters.
- Load-use compare stays inline.

Test Plan:
- Reset release, INIT_CYCLES=4 → pc_write=0 and idex_bubble=1 for exactly 4 cycles, then pc_write=1 and all bubbles 0.
- RUN, idex_memread=1, idex_rd=5, ifid_rs2=5, uses_rs2=1 → pc_write=0, ifid_write=0, idex_bubble=1, stall_cycles 0→1. Same case with idex_rd=0 → no stall.
- Load-use and ex_branch_taken in the same cycle → pc_write=1, ifid_flush=1, idex_bubble=1, flush_count=1, stall_cycles unchanged.
- dmem_req=1, dmem_ready=0 for 3 cycles, then ready → exmem_write=0 and memwb_bubble=1 for 3 cycles, then all writes=1; stall_cycles +3.
- dmem_ready held 0, DMEM_TIMEOUT=16 → mem_fault pulses once on the 16th wait cycle, halted=1 thereafter; asserting rst mid-HALT returns to INIT with counters 0.
- Force stall_cycles near all-ones (CNT_W=4), apply 20 stall cycles → the count holds at 15.
